// File: rtl/qspi_pkg.sv
// Shared QSPI definitions for the receive and transmit shifters.
package qspi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } rx_state_e;

  localparam int QSPI_NIBBLE   = 4;
  localparam int QSPI_MAX_BITS = 40;
  localparam int QSPI_CNT_W    = 6;

endpackage

// File: rtl/qspi_rx_sdi_dly.sv
// Single register stage on the quad input lines, used to absorb pad/flash
// round-trip delay ahead of the receive shifter.
module qspi_rx_sdi_dly
  import qspi_pkg::*;
#(
  parameter int W = QSPI_NIBBLE
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= '0;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/qspi_rshift.sv
// QSPI receive shifter: assembles nibbles LSB- or MSB-first into a word and
// hands it off over valid/ready. Optional input delay stage: QSPI_RX_SAMPLE_DELAY_EN.
module qspi_rshift
  import qspi_pkg::*;
#(
  parameter int MAX_BITS = QSPI_MAX_BITS,
  parameter int CNT_W    = QSPI_CNT_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                lsb_i,
  input  logic [CNT_W-1:0]    tsize_i,
  input  logic                abort_i,
  input  logic [3:0]          sdi_i,
  output logic [MAX_BITS-1:0] dout_o,
  output logic                dout_valid_o,
  input  logic                dout_ready_i,
  output logic                busy_o,
  output logic [CNT_W-1:0]    bit_index_o,
  output logic                r_intr_o,
  output logic                err_o
);

  localparam int               NIB_SLOTS = MAX_BITS / QSPI_NIBBLE;
  localparam logic [CNT_W-1:0] NIB_STEP  = CNT_W'(QSPI_NIBBLE);
  localparam logic [CNT_W-1:0] MAX_SIZE  = CNT_W'(MAX_BITS);

  rx_state_e state_reg;

  logic                     lsb_reg;
  logic [CNT_W-1:0]         tsz_reg;
  logic [CNT_W-1:0]         bit_index_reg;
  logic [MAX_BITS-1:0]      shadow_reg;
  logic [MAX_BITS-1:0]      shadow_next;
  logic [MAX_BITS-1:0]      dout_reg;
  logic                     valid_reg;
  logic                     busy_reg;
  logic                     intr_reg;
  logic                     err_reg;

  logic [CNT_W-1:0]         tsz_eff;
  logic [CNT_W-1:0]         nib_base;
  logic [CNT_W-1:0]         nib_slot;
  logic [QSPI_NIBBLE-1:0]   cap_data;
  logic                     cap_en;
  logic                     size_ok;
  logic                     last_nib;
  logic                     size_lsbs_unused;

  // Transfer sizes are whole nibbles; the two low size bits carry no meaning.
  assign tsz_eff          = {tsize_i[CNT_W-1:2], 2'b00};
  assign size_lsbs_unused = ^tsize_i[1:0];
  assign size_ok          = (tsz_eff != '0) && (tsz_eff <= MAX_SIZE);

  assign nib_base = lsb_reg ? bit_index_reg
                            : (tsz_reg - bit_index_reg - NIB_STEP);
  assign nib_slot = nib_base >> 2;
  assign last_nib = ((bit_index_reg + NIB_STEP) == tsz_reg);

  generate
    for (genvar gi = 0; gi < NIB_SLOTS; gi++) begin : g_slot
      assign shadow_next[gi*QSPI_NIBBLE +: QSPI_NIBBLE] =
          (nib_slot == CNT_W'(gi)) ? cap_data
                                   : shadow_reg[gi*QSPI_NIBBLE +: QSPI_NIBBLE];
    end
  endgenerate

`ifdef QSPI_RX_SAMPLE_DELAY_EN
  // The delay register still holds pre-window data on the first SHIFT edge,
  // so that edge is spent priming and captures nothing.
  logic prime_reg;

  qspi_rx_sdi_dly #(
    .W (QSPI_NIBBLE)
  ) u_sdi_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (sdi_i),
    .q_o   (cap_data)
  );

  assign cap_en = !prime_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      prime_reg <= 1'b0;
    end else if (state_reg == IDLE && start_i && size_ok) begin
      prime_reg <= 1'b1;
    end else if (state_reg == SHIFT) begin
      prime_reg <= 1'b0;
    end
  end
`else
  assign cap_data = sdi_i;
  assign cap_en   = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      lsb_reg       <= 1'b0;
      tsz_reg       <= '0;
      bit_index_reg <= '0;
      shadow_reg    <= '0;
      dout_reg      <= '0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      intr_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      intr_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (abort_i) begin
        state_reg     <= IDLE;
        bit_index_reg <= '0;
        busy_reg      <= 1'b0;
        valid_reg     <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start_i) begin
              if (size_ok) begin
                state_reg     <= SHIFT;
                lsb_reg       <= lsb_i;
                tsz_reg       <= tsz_eff;
                bit_index_reg <= '0;
                shadow_reg    <= '0;
                busy_reg      <= 1'b1;
              end else begin
                err_reg <= 1'b1;
              end
            end
          end
          SHIFT: begin
            if (cap_en) begin
              shadow_reg    <= shadow_next;
              bit_index_reg <= bit_index_reg + NIB_STEP;
              if (last_nib) begin
                state_reg <= HOLD;
                dout_reg  <= shadow_next;
                valid_reg <= 1'b1;
                intr_reg  <= 1'b1;
                busy_reg  <= 1'b0;
              end
            end
          end
          HOLD: begin
            if (dout_ready_i) begin
              state_reg <= IDLE;
              valid_reg <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout_o       = dout_reg;
  assign dout_valid_o = valid_reg;
  assign busy_o       = busy_reg;
  assign bit_index_o  = bit_index_reg;
  assign r_intr_o     = intr_reg;
  assign err_o        = err_reg;

endmodule

// File: tb/tb_qspi_rshift.sv
// Self-checking bench for qspi_rshift; reference word built from nibble placement rules.
module tb_qspi_rshift;

  localparam int MAX_BITS = 40;
  localparam int CNT_W    = 6;
`ifdef QSPI_RX_SAMPLE_DELAY_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                lsb;
  logic [CNT_W-1:0]    tsize;
  logic                abort;
  logic [3:0]          sdi;
  logic [MAX_BITS-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;
  logic                busy;
  logic [CNT_W-1:0]    bit_index;
  logic                r_intr;
  logic                err;

  int checks = 0;
  int errors = 0;
  logic [3:0] nibs [10];

  always #5 clk = ~clk;

  qspi_rshift #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .lsb_i        (lsb),
    .tsize_i      (tsize),
    .abort_i      (abort),
    .sdi_i        (sdi),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .dout_ready_i (dout_ready),
    .busy_o       (busy),
    .bit_index_o  (bit_index),
    .r_intr_o     (r_intr),
    .err_o        (err)
  );

  // Nibble k lands at 4k (LSB-first) or at size-4k-4 (MSB-first).
  function automatic logic [MAX_BITS-1:0] model_word(input bit l, input int eff);
    logic [MAX_BITS-1:0] w;
    int pos;
    w = '0;
    for (int k = 0; k < eff / 4; k++) begin
      pos = l ? 4 * k : eff - 4 * k - 4;
      w[pos +: 4] = nibs[k];
    end
    return w;
  endfunction

  task automatic run_xfer(input bit l, input int tsz_in, input int hold,
                          input bit poke_start, input string tag);
    int n, eff, exp_idx;
    logic [MAX_BITS-1:0] exp_w, held;
    eff   = (tsz_in / 4) * 4;
    n     = eff / 4;
    exp_w = model_word(l, eff);
    @(negedge clk);
    start = 1'b1; lsb = l; tsize = CNT_W'(tsz_in); sdi = nibs[0]; dout_ready = 1'b0;
    for (int c = 0; c < n + D; c++) begin
      @(negedge clk);
      start   = 1'b0;
      exp_idx = (c - D > 0) ? 4 * (c - D) : 0;
      checks++;
      if (busy !== 1'b1 || dout_valid !== 1'b0 || r_intr !== 1'b0) begin
        errors++;
        $display("FAIL %s shift_flags c=%0d busy=%b valid=%b intr=%b want 1/0/0", tag, c, busy, dout_valid, r_intr);
      end
      checks++;
      if (bit_index !== CNT_W'(exp_idx)) begin
        errors++;
        $display("FAIL %s bit_index c=%0d got %0d want %0d", tag, c, bit_index, exp_idx);
      end
      sdi = (c < n) ? nibs[c] : 4'($urandom);
    end
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b1 || r_intr !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_flags valid=%b intr=%b busy=%b want 1/1/0", tag, dout_valid, r_intr, busy);
    end
    checks++;
    if (dout !== exp_w) begin
      errors++;
      $display("FAIL %s dout got %h want %h", tag, dout, exp_w);
    end
    checks++;
    if (bit_index !== CNT_W'(eff)) begin
      errors++;
      $display("FAIL %s final_index got %0d want %0d", tag, bit_index, eff);
    end
    $display("xfer %s lsb=%0d tsize=%0d dout=%h", tag, l, tsz_in, dout);
    held = dout;
    for (int h = 0; h < hold; h++) begin
      start = poke_start;
      sdi   = 4'($urandom);
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b1 || r_intr !== 1'b0 || busy !== 1'b0 || dout !== held) begin
        errors++;
        $display("FAIL %s hold h=%0d valid=%b intr=%b busy=%b dout=%h want 1/0/0 %h", tag, h, dout_valid, r_intr, busy, dout, held);
      end
    end
    start = 1'b0;
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || r_intr !== 1'b0 || dout !== exp_w) begin
      errors++;
      $display("FAIL %s handoff valid=%b busy=%b intr=%b dout=%h want 0/0/0 %h", tag, dout_valid, busy, r_intr, dout, exp_w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; lsb = 1'b0; tsize = '0; abort = 1'b0; sdi = '0; dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dout !== '0 || dout_valid !== 1'b0 || busy !== 1'b0 || bit_index !== '0 || r_intr !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset dout=%h valid=%b busy=%b idx=%0d intr=%b err=%b want all 0", dout, dout_valid, busy, bit_index, r_intr, err);
    end
  endtask

  task automatic test_directed();
    nibs[0] = 4'hA; nibs[1] = 4'h5;
    run_xfer(1'b1, 8, 0, 1'b0, "lsb8");
    run_xfer(1'b0, 8, 0, 1'b0, "msb8");
    for (int k = 0; k < 10; k++) nibs[k] = 4'(k);
    run_xfer(1'b0, 40, 0, 1'b0, "msb40");
    run_xfer(1'b1, 40, 1, 1'b0, "lsb40");
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 10; k++) nibs[k] = 4'($urandom);
    run_xfer(1'b0, 24, 5, 1'b1, "backpressure");
  endtask

  task automatic test_illegal(input int tsz_in);
    @(negedge clk);
    start = 1'b1; lsb = 1'($urandom); tsize = CNT_W'(tsz_in);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_%0d err=%b busy=%b want 1/0", tsz_in, err, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_%0d_after err=%b busy=%b want 0/0", tsz_in, err, busy);
    end
  endtask

  task automatic test_odd_sizes();
    for (int k = 0; k < 10; k++) nibs[k] = 4'($urandom);
    run_xfer(1'b0, 7, 0, 1'b0, "tsize7");
    run_xfer(1'b0, 43, 0, 1'b0, "tsize43");
  endtask

  task automatic test_abort();
    for (int k = 0; k < 10; k++) nibs[k] = 4'($urandom);
    @(negedge clk);
    start = 1'b1; lsb = 1'b1; tsize = 6'd16; sdi = nibs[0];
    for (int c = 0; c < 4 + D; c++) begin
      @(negedge clk);
      start = 1'b0;
      sdi   = nibs[c];
    end
    checks++;
    if (bit_index !== 6'd12 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre idx=%0d busy=%b want 12/1", bit_index, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || bit_index !== '0 || dout_valid !== 1'b0 || r_intr !== 1'b0) begin
      errors++;
      $display("FAIL abort busy=%b idx=%0d valid=%b intr=%b want 0/0/0/0", busy, bit_index, dout_valid, r_intr);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b0 || r_intr !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_after c=%0d valid=%b intr=%b busy=%b want 0/0/0", c, dout_valid, r_intr, busy);
      end
    end
    $display("xfer abort tsize=16 after 3 captures");
    // abort together with start in IDLE must not open a window
    start = 1'b1; abort = 1'b1; tsize = 6'd8;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL abort_start busy=%b err=%b want 0/0", busy, err);
    end
  endtask

  task automatic test_rst_mid();
    for (int k = 0; k < 10; k++) nibs[k] = 4'(k + 1);
    run_xfer(1'b1, 40, 0, 1'b0, "pre_rst");
    @(negedge clk);
    start = 1'b1; lsb = 1'b0; tsize = 6'd40; sdi = 4'hF;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dout !== '0 || dout_valid !== 1'b0 || busy !== 1'b0 || bit_index !== '0 || r_intr !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid dout=%h valid=%b busy=%b idx=%0d intr=%b err=%b want all 0", dout, dout_valid, busy, bit_index, r_intr, err);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after busy=%b valid=%b want 0/0", busy, dout_valid);
    end
  endtask

  task automatic test_random();
    int tsz;
    bit l;
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < 10; k++) nibs[k] = 4'($urandom);
      tsz = int'($urandom_range(4, 43));
      l   = 1'($urandom);
      run_xfer(l, tsz, int'($urandom_range(0, 3)), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_illegal(0);
    test_illegal(44);
    test_illegal(63);
    test_odd_sizes();
    test_abort();
    test_random();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qspi_rshift.md
Name: qspi_rshift

Overview:
- Receive-side shifter for the QSPI master; sits beside the transmit shifter and downstream of the pad sampling path.
- Captures one 4-bit nibble from the quad data lines per clock while a receive window is open.
- Assembles up to 40 bits in LSB-first or MSB-first order.
- Hands the assembled word to the register/FIFO side over a valid/ready handshake and raises an interrupt pulse.

Parameters:
- MAX_BITS, 40, widest receive transfer in bits; must be a multiple of 4.
- CNT_W, 6, width of tsize and bit index; must satisfy 2^CNT_W > MAX_BITS.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle request to open a receive window; honoured only in IDLE.
- lsb_i  in  1  1 = first nibble lands at bits [3:0]; sampled with start_i.
- tsize_i  in  CNT_W  transfer length in bits; sampled with start_i.
- abort_i  in  1  abandons the transfer in any state.
- sdi_i  in  4  quad input lines; sdi_i[j] maps to bit (nibble base + j).
- dout_o  out  MAX_BITS  assembled word; bits at or above the effective size read 0.
- dout_valid_o  out  1  dout_o holds a completed word.
- dout_ready_i  in  1  consumer accepts dout_o.
- busy_o  out  1  high in SHIFT.
- bit_index_o  out  CNT_W  bits captured so far.
- r_intr_o  out  1  one-cycle pulse on completion.
- err_o  out  1  one-cycle pulse on an illegal tsize at start.

Behaviour:
- Reset: state IDLE; dout_o=0, dout_valid_o=0, busy_o=0, bit_index_o=0, r_intr_o=0, err_o=0. Applies mid-transfer; no partial data survives.
- Effective size tsz_eff = {tsize_i[CNT_W-1:2], 2'b00}; the low two bits are ignored.
- States: IDLE, SHIFT, HOLD.
- IDLE -> SHIFT:
  - On start_i with 0 < tsz_eff <= MAX_BITS.
  - Latch lsb and tsz_eff, clear the shadow word and bit index, set busy_o.
- IDLE + start_i with tsz_eff == 0 or > MAX_BITS: err_o pulses the next cycle, state stays IDLE.
- SHIFT, each edge:
  - Capture sdi_i into the shadow word.
  - lsb: nibble k goes to bits [4k+3:4k].
  - msb: nibble k goes to bits [tsz_eff-4k-1 : tsz_eff-4k-4], with sdi_i[j] at the lower offset +j.
  - bit_index += 4.
- SHIFT -> HOLD: on the edge where bit_index+4 == tsz_eff. The shadow word is copied to dout_o, and dout_valid_o=1 and r_intr_o=1 from the next cycle; busy_o drops.
- Latency: a start accepted at edge E0 captures at edges E1..EN (N = tsz_eff/4). dout_valid_o is high after EN.
- HOLD:
  - dout_o is stable while dout_valid_o && !dout_ready_i.
  - dout_valid_o && dout_ready_i -> IDLE at that edge; dout_valid_o=0 next cycle, dout_o retained.
  - r_intr_o is high only in the first HOLD cycle.
- start_i in SHIFT or HOLD: ignored, no error.
- abort_i, highest priority after reset, in any state:
  - Go to IDLE, clear bit_index_o, busy_o and dout_valid_o; no r_intr_o.
  - abort_i together with start_i in IDLE: stays IDLE.
- Ready may be high before valid; no combinational path from dout_ready_i to dout_valid_o.

Optional Feature:
- Macro QSPI_RX_SAMPLE_DELAY_EN.
- Defined: sdi_i passes through one extra register before capture, to compensate pad/flash round-trip delay. SHIFT lasts N+1 cycles. The first registered value is discarded, and valid arrives one cycle later than without the macro.
- Undefined: direct capture as above.

Decomposition:
- Shared package qspi_pkg:
  - enum rx_state_e {IDLE, SHIFT, HOLD};
  - localparam QSPI_NIBBLE = 4;
  - MAX_BITS default, shared with the transmit shifter.
- Sub-module qspi_rx_sdi_dly (1-4 bit register stage), instantiated only under QSPI_RX_SAMPLE_DELAY_EN. Everything else stays in one module.

Test Plan:
- lsb=1, tsize=8, sdi 0xA then 0x5 -> dout_o=0x00_0000_005A; valid 2 cycles after the start edge; r_intr_o for 1 cycle.
- lsb=0, tsize=8, same sdi -> dout_o=0xA5. lsb=0, tsize=40, nibbles 0..9 -> dout_o=0x01_2345_6789.
- Backpressure: dout_ready_i low 5 cycles in HOLD -> dout_o/valid stable, r_intr_o only in the first cycle, start_i ignored; ready high -> IDLE next cycle.
- tsize=0, tsize=44, tsize=7 -> err_o pulse for 0 and 44, no busy; tsize=7 runs as 4 bits, 1 capture.
- abort_i after 3 captures of tsize=16 -> IDLE next cycle, bit_index_o=0, no valid, no interrupt. Then rst_i mid-SHIFT -> all outputs at reset values.
- With QSPI_RX_SAMPLE_DELAY_EN, rerun case 1 -> identical dout_o, valid one cycle later.
